// File: rtl/mem_port_arbiter_if.sv
// Handshake and memory-bus bundle between the fetch/load-store requesters,
// the arbiter (slave modport) and the memory macro side (master modport).
interface mem_port_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) ();
  logic                  if_req;
  logic [ADDR_WIDTH-1:0] if_addr;
  logic                  if_gnt;
  logic                  if_rvalid;
  logic [DATA_WIDTH-1:0] if_rdata;

  logic                  dm_req;
  logic                  dm_we;
  logic [ADDR_WIDTH-1:0] dm_addr;
  logic [DATA_WIDTH-1:0] dm_wdata;
  logic                  dm_gnt;
  logic                  dm_rvalid;
  logic [DATA_WIDTH-1:0] dm_rdata;
  logic                  dm_err;

  logic                  mem_en;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata, dm_err,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata, dm_err,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter: load/store has fixed priority over fetch.
// Define MEM_ARB_STARVE_GUARD_EN to build in the fetch starvation guard.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    RESP_NONE   = 2'd0,
    RESP_IF     = 2'd1,
    RESP_DM_RD  = 2'd2,
    RESP_DM_ERR = 2'd3
  } resp_e;

  resp_e resp_q;
  resp_e resp_d;

  logic grant_if_s;
  logic grant_dm_s;
  logic dm_misaligned_s;
  logic dm_access_s;
  logic force_fetch_s;

  if ((STARVE_LIMIT < 1) || (STARVE_LIMIT > 15)) begin : g_bad_limit
    $error("mem_port_arbiter: STARVE_LIMIT must lie in 1..15");
  end

  assign dm_misaligned_s = (bus.dm_addr[1:0] != 2'b00);
  assign dm_access_s     = grant_dm_s & ~dm_misaligned_s;

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam logic [3:0] LIMIT_C = 4'(STARVE_LIMIT);

  logic [3:0] starve_q;
  logic [3:0] starve_d;

  assign force_fetch_s = (starve_q >= LIMIT_C);

  // Starvation counter register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      starve_q <= 4'd0;
    end else begin
      starve_q <= starve_d;
    end
  end

  // Count consecutive denied fetch cycles, saturating at 15.
  always_comb begin
    starve_d = 4'd0;
    if (rst_i) begin
      starve_d = 4'd0;
    end else if (bus.if_req && !grant_if_s) begin
      starve_d = (starve_q == 4'd15) ? 4'd15 : (starve_q + 4'd1);
    end else begin
      starve_d = 4'd0;
    end
  end
`else
  assign force_fetch_s = 1'b0;
`endif

  // Response owner register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      resp_q <= RESP_NONE;
    end else begin
      resp_q <= resp_d;
    end
  end

  // Grant selection: forced fetch, then data, then fetch.
  always_comb begin
    grant_if_s = 1'b0;
    grant_dm_s = 1'b0;
    if (rst_i) begin
      grant_if_s = 1'b0;
      grant_dm_s = 1'b0;
    end else if (force_fetch_s && bus.if_req) begin
      grant_if_s = 1'b1;
    end else if (bus.dm_req) begin
      grant_dm_s = 1'b1;
    end else if (bus.if_req) begin
      grant_if_s = 1'b1;
    end else begin
      grant_if_s = 1'b0;
      grant_dm_s = 1'b0;
    end
  end

  // Next response owner; writes complete at grant and owe no response.
  always_comb begin
    resp_d = RESP_NONE;
    if (rst_i) begin
      resp_d = RESP_NONE;
    end else if (grant_if_s) begin
      resp_d = RESP_IF;
    end else if (grant_dm_s) begin
      if (dm_misaligned_s) begin
        resp_d = RESP_DM_ERR;
      end else if (bus.dm_we) begin
        resp_d = RESP_NONE;
      end else begin
        resp_d = RESP_DM_RD;
      end
    end else begin
      resp_d = RESP_NONE;
    end
  end

  // Grant, memory-side and response outputs.
  always_comb begin
    bus.if_gnt    = grant_if_s;
    bus.dm_gnt    = grant_dm_s;
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = {ADDR_WIDTH{1'b0}};
    bus.mem_wdata = {DATA_WIDTH{1'b0}};
    if (grant_if_s) begin
      bus.mem_en   = 1'b1;
      bus.mem_addr = bus.if_addr;
    end else if (dm_access_s) begin
      bus.mem_en    = 1'b1;
      bus.mem_we    = bus.dm_we;
      bus.mem_addr  = bus.dm_addr;
      bus.mem_wdata = bus.dm_wdata;
    end else begin
      bus.mem_en = 1'b0;
    end

    bus.if_rvalid = 1'b0;
    bus.if_rdata  = {DATA_WIDTH{1'b0}};
    bus.dm_rvalid = 1'b0;
    bus.dm_rdata  = {DATA_WIDTH{1'b0}};
    bus.dm_err    = 1'b0;
    // resp_q still holds a stale owner during the first reset cycle.
    if (rst_i) begin
      bus.if_rvalid = 1'b0;
    end else begin
      case (resp_q)
        RESP_IF: begin
          bus.if_rvalid = 1'b1;
          bus.if_rdata  = bus.mem_rdata;
        end
        RESP_DM_RD: begin
          bus.dm_rvalid = 1'b1;
          bus.dm_rdata  = bus.mem_rdata;
        end
        RESP_DM_ERR: begin
          bus.dm_rvalid = 1'b1;
          bus.dm_err    = 1'b1;
        end
        default: begin
          bus.if_rvalid = 1'b0;
          bus.dm_rvalid = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed steps plus randomized
// traffic compared against a cycle-level reference model of the arbitration rules.
module tb_mem_port_arbiter;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int LIMIT = 4;
  localparam int WORDS = 128;
`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  mem_port_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  function automatic logic [31:0] init_word(input int i);
    return 32'h00500093 ^ (32'(i) * 32'h01010101);
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'(a[8:2]);
  endfunction

  // Behavioural synchronous-read memory macro driven by the DUT.
  logic [31:0]      macro_q [WORDS];
  logic [WORDS-1:0] written_q;
  logic [31:0]      mem_rdata_q;
  always @(posedge clk) begin
    if (rst) begin
      written_q <= '0;
    end else if (bus.mem_en && bus.mem_we) begin
      macro_q[widx(bus.mem_addr)]   <= bus.mem_wdata;
      written_q[widx(bus.mem_addr)] <= 1'b1;
    end
    if (bus.mem_en && !bus.mem_we) begin
      mem_rdata_q <= written_q[widx(bus.mem_addr)] ? macro_q[widx(bus.mem_addr)]
                                                   : init_word(widx(bus.mem_addr));
    end
  end
  assign bus.mem_rdata = mem_rdata_q;

  // Reference model state: expected response (0 none, 1 fetch, 2 load, 3 error).
  logic [31:0] ref_mem [WORDS];
  int          pend;
  logic [31:0] pend_data;
  int          starve;
  int          n_pend;
  logic [31:0] n_data;
  int          n_starve;
  bit          n_wr;
  int          n_wr_idx;
  logic [31:0] n_wr_data;
  bit          g_if;
  bit          g_dm;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit r, input bit ir, input logic [31:0] ia, input bit dr,
                       input bit dwe, input logic [31:0] da, input logic [31:0] dwd);
    rst          = r;
    bus.if_req   = ir;
    bus.if_addr  = ia;
    bus.dm_req   = dr;
    bus.dm_we    = dwe;
    bus.dm_addr  = da;
    bus.dm_wdata = dwd;
  endtask

  task automatic check_cycle();
    bit forced;
    bit mis;
    bit acc;
    @(negedge clk);
    forced = GUARD && (starve >= LIMIT) && bus.if_req;
    g_if   = !rst && (forced || (bus.if_req && !bus.dm_req));
    g_dm   = !rst && bus.dm_req && !g_if;
    mis    = (bus.dm_addr[1:0] != 2'b00);
    acc    = g_dm && !mis;

    chk("if_gnt", 32'(bus.if_gnt), 32'(g_if));
    chk("dm_gnt", 32'(bus.dm_gnt), 32'(g_dm));
    chk("mem_en", 32'(bus.mem_en), 32'(g_if || acc));
    chk("mem_we", 32'(bus.mem_we), 32'(acc && bus.dm_we));
    if (g_if) chk("mem_addr_if", bus.mem_addr, bus.if_addr);
    else if (acc) chk("mem_addr_dm", bus.mem_addr, bus.dm_addr);
    else if (rst) chk("mem_addr_rst", bus.mem_addr, 32'h0);
    if (acc && bus.dm_we) chk("mem_wdata", bus.mem_wdata, bus.dm_wdata);
    else if (rst) chk("mem_wdata_rst", bus.mem_wdata, 32'h0);

    chk("if_rvalid", 32'(bus.if_rvalid), 32'(!rst && pend == 1));
    chk("if_rdata", bus.if_rdata, (!rst && pend == 1) ? pend_data : 32'h0);
    chk("dm_rvalid", 32'(bus.dm_rvalid), 32'(!rst && (pend == 2 || pend == 3)));
    chk("dm_rdata", bus.dm_rdata, (!rst && pend == 2) ? pend_data : 32'h0);
    if (rst || pend == 2 || pend == 3) chk("dm_err", 32'(bus.dm_err), 32'(!rst && pend == 3));

    n_wr   = 1'b0;
    n_pend = 0;
    n_data = 32'h0;
    if (rst) begin
      n_starve = 0;
    end else begin
      n_starve = (bus.if_req && !g_if) ? ((starve < 15) ? starve + 1 : 15) : 0;
      if (g_if) begin
        n_pend = 1;
        n_data = ref_mem[widx(bus.if_addr)];
      end else if (g_dm && mis) begin
        n_pend = 3;
      end else if (acc && bus.dm_we) begin
        n_wr      = 1'b1;
        n_wr_idx  = widx(bus.dm_addr);
        n_wr_data = bus.dm_wdata;
      end else if (acc) begin
        n_pend = 2;
        n_data = ref_mem[widx(bus.dm_addr)];
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (n_wr) ref_mem[n_wr_idx] = n_wr_data;
    if (rst) begin
      for (int i = 0; i < WORDS; i++) ref_mem[i] = init_word(i);
    end
    pend      = n_pend;
    pend_data = n_data;
    starve    = n_starve;
    #1;
  endtask

  initial begin
    for (int i = 0; i < WORDS; i++) ref_mem[i] = init_word(i);
    pend      = 0;
    pend_data = 32'h0;
    starve    = 0;
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(posedge clk);
    #1;
    check_cycle(); tick();
    check_cycle(); tick();

    // Single fetch of word 0.
    drive(1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    check_cycle();
    chk("fetch_gnt", 32'(bus.if_gnt), 32'h1);
    chk("fetch_mem_en", 32'(bus.mem_en), 32'h1);
    chk("fetch_mem_we", 32'(bus.mem_we), 32'h0);
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    check_cycle();
    chk("fetch_rvalid", 32'(bus.if_rvalid), 32'h1);
    chk("fetch_rdata", bus.if_rdata, 32'h00500093);
    tick();

    // Store then load of 0x100.
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h100, 32'hDEADBEEF);
    check_cycle();
    chk("wr_mem_we", 32'(bus.mem_we), 32'h1);
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h100, 32'h0);
    check_cycle();
    chk("wr_no_rvalid", 32'(bus.dm_rvalid), 32'h0);
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    check_cycle();
    chk("rd_rvalid", 32'(bus.dm_rvalid), 32'h1);
    chk("rd_rdata", bus.dm_rdata, 32'hDEADBEEF);
    tick();

    // Contention: data first, fetch the cycle after dm_req drops.
    drive(1'b0, 1'b1, 32'h10, 1'b1, 1'b0, 32'h20, 32'h0);
    check_cycle();
    chk("cont_dm_gnt", 32'(bus.dm_gnt), 32'h1);
    chk("cont_if_gnt", 32'(bus.if_gnt), 32'h0);
    tick();
    drive(1'b0, 1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0);
    check_cycle();
    chk("cont_if_late_gnt", 32'(bus.if_gnt), 32'h1);
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    check_cycle();
    chk("cont_if_rdata", bus.if_rdata, init_word(4));
    tick();

    // Continuous contention: fetch wins every LIMIT+1 cycles only with the guard.
    for (int k = 0; k < 2 * (LIMIT + 1); k++) begin
      drive(1'b0, 1'b1, 32'h40, 1'b1, 1'b0, 32'h80, 32'h0);
      check_cycle();
      chk("starve_if_gnt", 32'(bus.if_gnt), 32'(GUARD && ((k % (LIMIT + 1)) == LIMIT)));
      tick();
    end
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    check_cycle(); tick();

    // Misaligned read and write never reach memory.
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h102, 32'h0);
    check_cycle();
    chk("mis_rd_gnt", 32'(bus.dm_gnt), 32'h1);
    chk("mis_rd_mem_en", 32'(bus.mem_en), 32'h0);
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h1F3, 32'h12345678);
    check_cycle();
    chk("mis_rd_err", 32'(bus.dm_err), 32'h1);
    chk("mis_rd_rdata", bus.dm_rdata, 32'h0);
    chk("mis_wr_mem_en", 32'(bus.mem_en), 32'h0);
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h1F0, 32'h0);
    check_cycle();
    chk("mis_wr_err", 32'(bus.dm_err), 32'h1);
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    check_cycle();
    chk("mis_wr_untouched", bus.dm_rdata, init_word(124));
    tick();

    // Reset with a fetch response pending and both requests raised.
    drive(1'b0, 1'b1, 32'h8, 1'b0, 1'b0, 32'h0, 32'h0);
    check_cycle(); tick();
    drive(1'b1, 1'b1, 32'h8, 1'b1, 1'b0, 32'hC, 32'h0);
    check_cycle();
    chk("rst_if_rvalid", 32'(bus.if_rvalid), 32'h0);
    chk("rst_gnt", 32'(bus.if_gnt | bus.dm_gnt), 32'h0);
    chk("rst_mem_en", 32'(bus.mem_en), 32'h0);
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    check_cycle();
    chk("post_rst_rvalid", 32'(bus.if_rvalid | bus.dm_rvalid), 32'h0);
    tick();

    // Randomized traffic obeying the hold-until-granted rule.
    begin
      bit          ip;
      bit          dp;
      bit          dwe;
      bit          r;
      logic [31:0] ia;
      logic [31:0] da;
      logic [31:0] dwd;
      ip  = 1'b0;
      dp  = 1'b0;
      dwe = 1'b0;
      ia  = 32'h0;
      da  = 32'h0;
      dwd = 32'h0;
      for (int c = 0; c < 600; c++) begin
        r = ($urandom_range(0, 99) == 0);
        if (!ip) begin
          ip = ($urandom_range(0, 2) != 0);
          ia = $urandom_range(0, 127) << 2;
        end
        if (!dp) begin
          dp  = ($urandom_range(0, 1) == 1);
          dwe = ($urandom_range(0, 1) == 1);
          da  = $urandom_range(0, 511);
          if ($urandom_range(0, 3) != 0) da[1:0] = 2'b00;
          dwd = $urandom;
        end
        drive(r, ip, ia, dp, dwe, da, dwd);
        check_cycle();
        if (g_if || r) ip = 1'b0;
        if (g_dm || r) dp = 1'b0;
        tick();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
